// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: opcodes, branch funct3,
// datapath select encodings, FSM states and instruction classification helpers.
package riscv_ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  typedef enum logic [2:0] {
    ImmI = 3'd0,
    ImmS = 3'd1,
    ImmB = 3'd2,
    ImmU = 3'd3,
    ImmJ = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    WbMem = 2'd0,
    WbAlu = 2'd1,
    WbPc4 = 2'd2
  } wb_sel_e;

  localparam logic PcPlus4 = 1'b0;
  localparam logic PcAlu   = 1'b1;
  localparam logic ASelReg = 1'b0;
  localparam logic ASelPc  = 1'b1;
  localparam logic BSelReg = 1'b0;
  localparam logic BSelImm = 1'b1;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} ctrl_state_e;

  typedef enum logic [3:0] {
    ClsR, ClsIAlu, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsLui, ClsAuipc, ClsIllegal
  } inst_class_e;

  function automatic inst_class_e decode_class(input logic [6:0] opcode,
                                               input logic [2:0] funct3);
    inst_class_e cls;
    case (opcode)
      OpR:      cls = ClsR;
      OpIAlu:   cls = ClsIAlu;
      OpLoad:   cls = ClsLoad;
      OpStore:  cls = ClsStore;
      // funct3 010/011 are unassigned branch encodings
      OpBranch: cls = (funct3[2:1] == 2'b01) ? ClsIllegal : ClsBranch;
      OpJal:    cls = ClsJal;
      OpJalr:   cls = ClsJalr;
      OpLui:    cls = ClsLui;
      OpAuipc:  cls = ClsAuipc;
      default:  cls = ClsIllegal;
    endcase
    return cls;
  endfunction

  function automatic imm_sel_e imm_sel_for(input inst_class_e cls);
    imm_sel_e sel;
    case (cls)
      ClsStore:         sel = ImmS;
      ClsBranch:        sel = ImmB;
      ClsLui, ClsAuipc: sel = ImmU;
      ClsJal:           sel = ImmJ;
      default:          sel = ImmI;
    endcase
    return sel;
  endfunction

  function automatic logic a_sel_for(input inst_class_e cls);
    return (cls == ClsAuipc || cls == ClsJal || cls == ClsBranch) ? ASelPc : ASelReg;
  endfunction

  function automatic logic b_sel_for(input inst_class_e cls);
    return (cls == ClsR || cls == ClsIllegal) ? BSelReg : BSelImm;
  endfunction

endpackage

// File: rtl/riscv_mc_control_if.sv
// Control-unit <-> datapath bundle: fetched instruction, compare flags, DMEM handshake
// and all control strobes. master = control unit, slave = datapath/memory side.
interface riscv_mc_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      inst;
  logic             BrEq;
  logic             BrLT;
  logic             mem_ready;
  logic             PCSel;
  logic [2:0]       ImmSel;
  logic             RegWEn;
  logic             BrUn;
  logic             BSel;
  logic             ASel;
  logic             MemRW;
  logic [1:0]       WBSel;
  logic             PCWEn;
  logic             IRWEn;
  logic             retire;
  logic [CNT_W-1:0] instret;
  logic             illegal;

  modport master (
    input  inst, BrEq, BrLT, mem_ready,
    output PCSel, ImmSel, RegWEn, BrUn, BSel, ASel, MemRW, WBSel,
    output PCWEn, IRWEn, retire, instret, illegal
  );

  modport slave (
    output inst, BrEq, BrLT, mem_ready,
    input  PCSel, ImmSel, RegWEn, BrUn, BSel, ASel, MemRW, WBSel,
    input  PCWEn, IRWEn, retire, instret, illegal
  );
endinterface

// File: rtl/riscv_branch_resolve.sv
// Branch condition resolution from funct3 and the datapath compare flags.
module riscv_branch_resolve
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_br_eq,
  input  logic       i_br_lt,
  output logic       o_br_un,
  output logic       o_taken
);

  assign o_br_un = i_funct3[1];

  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      F3Beq:          o_taken = i_br_eq;
      F3Bne:          o_taken = ~i_br_eq;
      F3Blt, F3Bltu:  o_taken = i_br_lt;
      F3Bge, F3Bgeu:  o_taken = ~i_br_lt;
      default:        o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with PC/IR strobes,
// DMEM ready handshake, retired-instruction counter and sticky illegal trap.
module riscv_mc_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_PC_HOLD = 1
) (
  input logic                clk,
  input logic                rst_n,
  riscv_mc_control_if.master bus
);

  localparam logic [1:0] HoldInit = 2'(RST_PC_HOLD);

  ctrl_state_e      r_state, w_state_nxt;
  logic [1:0]       r_hold, w_hold_nxt;
  logic [31:0]      r_ir;
  logic [CNT_W-1:0] r_instret;
  logic             r_illegal;

  inst_class_e w_cls;
  logic        w_br_un, w_taken;
  logic        w_irwen, w_pcwen, w_regwen, w_memrw, w_pcsel, w_brun, w_asel, w_bsel;
  imm_sel_e    w_imm_sel;
  wb_sel_e     w_wb_sel;
  logic        w_unused_ir;

  assign w_cls       = decode_class(r_ir[6:0], r_ir[14:12]);
  assign w_unused_ir = ^{r_ir[31:15], r_ir[11:7]};

  riscv_branch_resolve u_branch (
    .i_funct3 (r_ir[14:12]),
    .i_br_eq  (bus.BrEq),
    .i_br_lt  (bus.BrLT),
    .o_br_un  (w_br_un),
    .o_taken  (w_taken)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_irwen     = 1'b0;
    w_pcwen     = 1'b0;
    w_regwen    = 1'b0;
    w_memrw     = 1'b0;
    w_pcsel     = PcPlus4;
    w_brun      = 1'b0;
    w_asel      = ASelReg;
    w_bsel      = BSelReg;
    w_imm_sel   = ImmI;
    w_wb_sel    = WbMem;
    unique case (r_state)
      FETCH: begin
        if (r_hold != 2'd0) begin
          w_hold_nxt = r_hold - 2'd1;
        end else begin
          w_irwen     = 1'b1;
          w_state_nxt = DECODE;
        end
      end
      DECODE: begin
        w_imm_sel   = imm_sel_for(w_cls);
        w_state_nxt = (w_cls == ClsIllegal) ? TRAP : EXEC;
      end
      EXEC: begin
        w_imm_sel = imm_sel_for(w_cls);
        w_asel    = a_sel_for(w_cls);
        w_bsel    = b_sel_for(w_cls);
        case (w_cls)
          ClsBranch: begin
            w_brun      = w_br_un;
            w_pcsel     = w_taken;
            w_pcwen     = 1'b1;
            w_state_nxt = FETCH;
          end
          ClsLoad, ClsStore: w_state_nxt = MEM;
          default:           w_state_nxt = WB;
        endcase
      end
      MEM: begin
        w_imm_sel = imm_sel_for(w_cls);
        w_asel    = a_sel_for(w_cls);
        w_bsel    = b_sel_for(w_cls);
        w_memrw   = (w_cls == ClsStore);
        if (bus.mem_ready) begin
          // Stores retire straight out of MEM; loads still need a writeback cycle
          if (w_cls == ClsStore) begin
            w_pcwen     = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = WB;
          end
        end
      end
      WB: begin
        w_imm_sel   = imm_sel_for(w_cls);
        w_asel      = a_sel_for(w_cls);
        w_bsel      = b_sel_for(w_cls);
        w_regwen    = 1'b1;
        w_pcwen     = 1'b1;
        w_state_nxt = FETCH;
        case (w_cls)
          ClsLoad:        w_wb_sel = WbMem;
          ClsJal, ClsJalr: begin
            w_wb_sel = WbPc4;
            w_pcsel  = PcAlu;
          end
          default:        w_wb_sel = WbAlu;
        endcase
      end
      TRAP:    w_state_nxt = TRAP;
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_hold    <= HoldInit;
      r_ir      <= '0;
      r_instret <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      if (w_irwen) begin
        r_ir <= bus.inst;
      end
      if (w_pcwen) begin
        r_instret <= r_instret + CNT_W'(1);
      end
      if (r_state == DECODE && w_cls == ClsIllegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Reset state is FETCH; with no hold configured IRWEn must still stay low in reset
  assign bus.IRWEn   = w_irwen & rst_n;
  assign bus.PCWEn   = w_pcwen;
  assign bus.retire  = w_pcwen;
  assign bus.RegWEn  = w_regwen;
  assign bus.MemRW   = w_memrw;
  assign bus.PCSel   = w_pcsel;
  assign bus.BrUn    = w_brun;
  assign bus.ASel    = w_asel;
  assign bus.BSel    = w_bsel;
  assign bus.ImmSel  = w_imm_sel;
  assign bus.WBSel   = w_wb_sel;
  assign bus.instret = r_instret;
  assign bus.illegal = r_illegal;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Scoreboard bench for riscv_mc_control: stimulus queues expected strobe-cycle vectors,
// a negedge monitor pops and compares them whenever the DUT raises any strobe.
module tb_riscv_mc_control;

  localparam int unsigned CntW = 4;
  localparam int unsigned Hold = 1;

  typedef struct packed {
    logic       pcsel;
    logic [2:0] imm;
    logic       regwen;
    logic       brun;
    logic       bsel;
    logic       asel;
    logic       memrw;
    logic [1:0] wbsel;
    logic       pcwen;
    logic       irwen;
    logic       retire;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string            name;
    int               gap;
    ctl_t             ctl;
    logic [CntW-1:0]  ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   gap_cnt = 0;
  exp_t exp_q[$];
  logic [CntW-1:0] exp_ret = '0;

  riscv_mc_control_if #(.CNT_W(CntW)) bus ();

  riscv_mc_control #(
    .CNT_W       (CntW),
    .RST_PC_HOLD (Hold)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic ctl_t cur_ctl();
    return {bus.PCSel, bus.ImmSel, bus.RegWEn, bus.BrUn, bus.BSel, bus.ASel, bus.MemRW,
            bus.WBSel, bus.PCWEn, bus.IRWEn, bus.retire, bus.illegal};
  endfunction

  // f = {pcsel, imm[2:0], regwen, brun, bsel, asel, memrw, wbsel[1:0]}; final cycle retires
  function automatic ctl_t cv(input logic [10:0] f);
    ctl_t c;
    c = '0;
    {c.pcsel, c.imm, c.regwen, c.brun, c.bsel, c.asel, c.memrw, c.wbsel} = f;
    c.pcwen  = 1'b1;
    c.retire = 1'b1;
    return c;
  endfunction

  function automatic ctl_t fetch_v();
    ctl_t c;
    c = '0;
    c.irwen = 1'b1;
    return c;
  endfunction

  function automatic ctl_t stall_of(input ctl_t fin);
    ctl_t c;
    c = fin;
    c.pcwen  = 1'b0;
    c.retire = 1'b0;
    return c;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic push(input string nm, input int gap, input ctl_t c);
    exp_t e;
    e.name = nm;
    e.gap  = gap;
    e.ctl  = c;
    e.ret  = exp_ret;
    exp_q.push_back(e);
  endtask

  // Called one step after a rising edge with the DUT about to spend a cycle in FETCH.
  task automatic run(input string nm, input logic [31:0] ins, input logic eq, input logic lt,
                     input int stalls, input int ncyc, input int fgap, input int lgap,
                     input ctl_t fin);
    push(nm, fgap, fetch_v());
    if (fin.memrw) begin
      for (int s = 0; s < stalls; s++) push(nm, (s == 0) ? lgap : 1, stall_of(fin));
    end
    push(nm, (fin.memrw && stalls > 0) ? 1 : lgap, fin);
    exp_ret++;
    bus.inst = ins;
    bus.BrEq = eq;
    bus.BrLT = lt;
    for (int c = 0; c < ncyc; c++) begin
      bus.mem_ready = !(c >= 3 && c < 3 + stalls);
      @(posedge clk);
      #1;
      if (c == 0) bus.inst = 32'hFFFF_FFFF;
    end
  endtask

  task automatic trap_run(input string nm, input logic [31:0] ins, input int fgap);
    push(nm, fgap, fetch_v());
    bus.inst = ins;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      bus.inst = 32'hFFFF_FFFF;
    end
    check({nm, "_flag_after_decode"}, 32'(bus.illegal), 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
    end
    check({nm, "_flag_sticky"}, 32'(bus.illegal), 32'd1);
    check({nm, "_instret"}, 32'(bus.instret), 32'(exp_ret));
  endtask

  task automatic reset_pulse(input string nm);
    rst_n = 1'b0;
    #1;
    check({nm, "_ctl"}, 32'(cur_ctl()), 32'd0);
    check({nm, "_instret"}, 32'(bus.instret), 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_ret = '0;
    for (int c = 0; c < int'(Hold); c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    ctl_t act;
    if (!rst_n) begin
      gap_cnt = 0;
    end else begin
      gap_cnt++;
      act = cur_ctl();
      if (act.irwen | act.pcwen | act.memrw | act.regwen) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_strobe: got ctl=%b, no strobe expected", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e.ctl || bus.instret !== e.ret || gap_cnt != e.gap) begin
            n_err++;
            $display("FAIL %s: got ctl=%b instret=%0d gap=%0d, expected ctl=%b instret=%0d gap=%0d",
                     e.name, act, bus.instret, gap_cnt, e.ctl, e.ret, e.gap);
          end
        end
        gap_cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

  localparam logic [31:0] InstSw = 32'h0050_A623;

  initial begin
    bus.inst      = 32'hFFFF_FFFF;
    bus.BrEq      = 1'b0;
    bus.BrLT      = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    check("reset_ctl", 32'(cur_ctl()), 32'd0);
    check("reset_instret", 32'(bus.instret), 32'd0);
    check("reset_illegal", 32'(bus.illegal), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < int'(Hold); c++) begin
      @(posedge clk);
      #1;
    end

    run("add",     32'h0020_81B3, 1'b0, 1'b0, 0, 4, Hold + 1, 3, cv(11'b0_000_1_0_0_0_0_01));
    run("addi",    32'h0010_0093, 1'b0, 1'b0, 0, 4, 1, 3, cv(11'b0_000_1_0_1_0_0_01));
    run("lw",      32'h0080_A283, 1'b0, 1'b0, 2, 7, 1, 6, cv(11'b0_000_1_0_1_0_0_00));
    run("sw",      InstSw,        1'b0, 1'b0, 0, 4, 1, 3, cv(11'b0_001_0_0_1_0_1_00));
    run("sw_stall", InstSw,       1'b0, 1'b0, 1, 5, 1, 3, cv(11'b0_001_0_0_1_0_1_00));
    run("beq_tk",  32'h0020_8863, 1'b1, 1'b0, 0, 3, 1, 2, cv(11'b1_010_0_0_1_1_0_00));
    run("beq_nt",  32'h0020_8863, 1'b0, 1'b0, 0, 3, 1, 2, cv(11'b0_010_0_0_1_1_0_00));
    run("bltu_tk", 32'h0020_E863, 1'b0, 1'b1, 0, 3, 1, 2, cv(11'b1_010_0_1_1_1_0_00));
    run("bge_nt",  32'h0020_D863, 1'b0, 1'b1, 0, 3, 1, 2, cv(11'b0_010_0_0_1_1_0_00));
    run("jal",     32'h0080_00EF, 1'b0, 1'b0, 0, 4, 1, 3, cv(11'b1_100_1_0_1_1_0_10));
    run("jalr",    32'h0001_00E7, 1'b0, 1'b0, 0, 4, 1, 3, cv(11'b1_000_1_0_1_0_0_10));
    run("lui",     32'h1234_52B7, 1'b0, 1'b0, 0, 4, 1, 3, cv(11'b0_011_1_0_1_0_0_01));
    run("auipc",   32'h0000_1297, 1'b0, 1'b0, 0, 4, 1, 3, cv(11'b0_011_1_0_1_1_0_01));
    check("instret_13", 32'(bus.instret), 32'd13);
    for (int i = 0; i < 3; i++) begin
      run("addi_wrap", 32'h0010_0093, 1'b0, 1'b0, 0, 4, 1, 3, cv(11'b0_000_1_0_1_0_0_01));
    end
    check("instret_wrap", 32'(bus.instret), 32'd0);

    trap_run("illegal_ones", 32'hFFFF_FFFF, 1);
    reset_pulse("trap_reset");
    run("add_after_trap", 32'h0020_81B3, 1'b0, 1'b0, 0, 4, Hold + 1, 3,
        cv(11'b0_000_1_0_0_0_0_01));
    check("instret_after_trap", 32'(bus.instret), 32'd1);
    trap_run("illegal_br_f3", 32'h0020_A863, 1);

    // Abort a stalled store in MEM with an asynchronous reset
    reset_pulse("abort_setup");
    push("sw_abort", Hold + 1, fetch_v());
    push("sw_abort", 3, stall_of(cv(11'b0_001_0_0_1_0_1_00)));
    bus.inst      = InstSw;
    bus.mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      bus.inst = 32'hFFFF_FFFF;
    end
    @(negedge clk);
    #1;
    check("abort_memrw_before", 32'(bus.MemRW), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_memrw_async", 32'(bus.MemRW), 32'd0);
    check("abort_ctl", 32'(cur_ctl()), 32'd0);
    check("abort_instret", 32'(bus.instret), 32'd0);
    #20;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
